v_counter_sched: RTL and testbench
==================================

Name: v_counter_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit signed up/down counter among NREQ requesters.
- Each requester posts an operation (increment, decrement, load, clear) with a REQ/GNT handshake.
- The block arbitrates, executes exactly one operation per grant and reports wrap events.
- Sits between several control agents and a single shared signed count register, Q.

Parameters:
- WIDTH, 4, counter width in bits; signed two's complement; min 2.
- NREQ, 4, number of requesters; 2..8.

Ports:
- C  input  1  clock; all logic on rising edge.
- R  input  1  reset; synchronous and active-high.
- REQ  input  NREQ  request per requester; level, held until granted.
- OP  input  2*NREQ  opcode per requester; bits [2i+1:2i] belong to requester i; 00 inc, 01 dec, 10 load, 11 clear.
- DIN  input  WIDTH*NREQ  signed load value per requester; bits [WIDTH*i+WIDTH-1:WIDTH*i]; used only for load.
- GNT  output  NREQ  one-hot grant; high for exactly one cycle per executed op.
- BUSY  output  1  high in EXEC and GAP states.
- Q  output signed  WIDTH  shared counter value, registered.
- WRAP  output  1  one-cycle pulse; the executed op crossed max->min or min->max.

Behaviour:
- Reset (R=1 at a rising edge of C): state=IDLE, Q=0, GNT=0, WRAP=0, BUSY=0, round-robin pointer PTR=0. Reset overrides everything, including an op in progress.
- States: IDLE, EXEC, GAP.
- IDLE, REQ==0: stay in IDLE.
- IDLE, REQ!=0: select winner W.
  - W is the first requester with REQ set, scanning PTR, PTR+1, ... modulo NREQ.
  - Latch W, OP[W] and DIN[W] into internal registers; go to EXEC.
- EXEC (one cycle):
  - GNT[W]=1, BUSY=1.
  - At the end of the cycle, Q is updated from the latched op; the new Q is visible the cycle after GNT.
  - Next state GAP; PTR <= (W+1) mod NREQ.
- GAP (one cycle): GNT=0, BUSY=1, no arbitration; next state IDLE.
- Requester rules:
  - Hold REQ/OP/DIN stable until GNT is seen.
  - Drop REQ the cycle after GNT, or keep it high to post a new op, which queues behind the others.
  - Changing OP/DIN after the IDLE sampling cycle has no effect on the current op.
- Latency: REQ high in IDLE -> GNT next cycle -> Q updated the following cycle. Maximum throughput is one op per 3 cycles.
- Fairness: a requester holding REQ continuously is granted within NREQ arbitration rounds.
- Arithmetic:
  - inc: Q+1. dec: Q-1. load: Q=DIN[W]. clear: Q=0.
  - Default is modulo 2^WIDTH wrap: WIDTH=4 gives 7+1 -> -8 and -8-1 -> 7.
- WRAP:
  - Pulses in the cycle Q takes the wrapped value, i.e. the cycle after GNT.
  - Only inc from max or dec from min set it; load and clear never set it.
- Simultaneous requests are resolved purely by PTR; lower index wins only when PTR=0.
- REQ deasserted during EXEC: the op still completes.
- R asserted during EXEC: the op is discarded and no WRAP is produced.

Optional Feature:
- Macro: V_COUNTER_SCHED_SAT_EN.
- Defined: inc at max and dec at min saturate; Q holds max (or min). WRAP still pulses, meaning "saturation hit".
- Undefined: modulo wrap as above. All other behaviour is identical.

Test Plan (WIDTH=4, NREQ=4):
- Reset: R=1 for 2 cycles with REQ=4'b1111 -> Q=0, GNT=0, BUSY=0, WRAP=0; no grant until the cycle after R falls.
- Single inc: REQ[2]=1, OP[2]=00, from Q=3 -> GNT=4'b0100 the next cycle, Q=4 the cycle after, BUSY high for 2 cycles.
- Round-robin: REQ=4'b1111 held, all ops inc, from Q=0 -> grant order 0,1,2,3,0; each GNT separated by 3 cycles; Q=5 after the fifth op.
- Wrap:
  - Load 7 via requester 1, then inc via requester 3 -> Q=-8 with a WRAP pulse.
  - Then dec -> Q=7 with a WRAP pulse.
  - With V_COUNTER_SCHED_SAT_EN, the same sequence gives Q=7 then 6, with a WRAP pulse on the inc only.
- Load/clear: requester 0 loads DIN=-3 -> Q=-3, WRAP=0; requester 2 clears -> Q=0, WRAP=0.
- Mid-op reset: assert R in the EXEC cycle of a load of 5 from Q=2 -> Q=0 next cycle, state IDLE, PTR=0; the next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/v_counter_sched.sv
// v_counter_sched: round-robin scheduler sharing one signed up/down counter.
// Define V_COUNTER_SCHED_SAT_EN to saturate at max/min instead of wrapping.
module v_counter_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                     C,
    input  logic                     R,
    input  logic [NREQ-1:0]          REQ,
    input  logic [2*NREQ-1:0]        OP,
    input  logic [WIDTH*NREQ-1:0]    DIN,
    output logic [NREQ-1:0]          GNT,
    output logic                     BUSY,
    output logic signed [WIDTH-1:0]  Q,
    output logic                     WRAP
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_LD  = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic signed [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0]         G1   = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        GAP
    } state_t;

    state_t                   state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            win;
    logic [1:0]               lop;
    logic signed [WIDTH-1:0]  ldin;

    logic [1:0]               op_a  [NREQ];
    logic [WIDTH-1:0]         din_a [NREQ];

    logic                     found;
    logic [PW-1:0]            pick;
    logic [PW:0]              scan;

    logic signed [WIDTH-1:0]  q_nxt;
    logic                     wrap_nxt;
    logic [PW-1:0]            ptr_nxt;

    // split the flat opcode and load-value buses into per-requester slots
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i]  = OP[2*i +: 2];
            din_a[i] = DIN[WIDTH*i +: WIDTH];
        end
    end

    // first requesting index at or after ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(NREQ))
                scan = scan - (PW+1)'(NREQ);
            if (!found && REQ[scan[PW-1:0]]) begin
                found = 1'b1;
                pick  = scan[PW-1:0];
            end
        end
    end

    // pointer moves to the slot just past the current winner
    always_comb begin
        if (win == PW'(NREQ-1))
            ptr_nxt = '0;
        else
            ptr_nxt = win + PW'(1);
    end

    // counter result and wrap flag for the latched operation
    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        case (lop)
            OP_INC: begin
                if (Q == QMAX) begin
                    wrap_nxt = 1'b1;
`ifdef V_COUNTER_SCHED_SAT_EN
                    q_nxt = QMAX;
`else
                    q_nxt = QMIN;
`endif
                end else begin
                    q_nxt = Q + ONE;
                end
            end
            OP_DEC: begin
                if (Q == QMIN) begin
                    wrap_nxt = 1'b1;
`ifdef V_COUNTER_SCHED_SAT_EN
                    q_nxt = QMIN;
`else
                    q_nxt = QMAX;
`endif
                end else begin
                    q_nxt = Q - ONE;
                end
            end
            OP_LD:   q_nxt = ldin;
            OP_CLR:  q_nxt = '0;
            default: q_nxt = Q;
        endcase
    end

    // IDLE -> EXEC -> GAP sequencer with registered outputs
    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            lop   <= OP_INC;
            ldin  <= '0;
            GNT   <= '0;
            BUSY  <= 1'b0;
            Q     <= '0;
            WRAP  <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        win   <= pick;
                        lop   <= op_a[pick];
                        ldin  <= din_a[pick];
                        GNT   <= G1 << pick;
                        BUSY  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    GNT   <= '0;
                    Q     <= q_nxt;
                    WRAP  <= wrap_nxt;
                    ptr   <= ptr_nxt;
                    state <= GAP;
                end
                GAP: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_counter_sched.sv
// tb_v_counter_sched: directed bench for the shared counter scheduler.
// Expected values are hand-derived for WIDTH=4, NREQ=4.
module tb_v_counter_sched;

    logic              C;
    logic              R;
    logic [3:0]        REQ;
    logic [7:0]        OP;
    logic [15:0]       DIN;
    logic [3:0]        GNT;
    logic              BUSY;
    logic signed [3:0] Q;
    logic              WRAP;

    int total = 0;
    int bad   = 0;

    v_counter_sched #(.WIDTH(4), .NREQ(4)) dut (
        .C(C), .R(R), .REQ(REQ), .OP(OP), .DIN(DIN),
        .GNT(GNT), .BUSY(BUSY), .Q(Q), .WRAP(WRAP)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic post(input int idx, input logic [1:0] op, input logic [3:0] d);
        REQ[idx]         = 1'b1;
        OP[2*idx +: 2]   = op;
        DIN[4*idx +: 4]  = d;
    endtask

    task automatic run_op(input int idx, input logic [1:0] op, input logic [3:0] d);
        REQ = 4'b0000;
        post(idx, op, d);
        tick;
        REQ = 4'b0000;
        tick;
        tick;
    endtask

    task automatic test_reset;
        R = 1'b1;
        REQ = 4'b1111;
        OP = 8'h00;
        DIN = 16'h0000;
        tick;
        tick;
        total++; if (Q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%0d exp=0", Q); end
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", GNT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", WRAP); end
        R = 1'b0;
        tick;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", GNT); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== 4'sd1) begin bad++; $display("FAIL reset_first_q got=%0d exp=1", Q); end
        tick;
    endtask

    task automatic test_single_inc;
        run_op(2, 2'b10, 4'd3);
        REQ = 4'b0000;
        post(2, 2'b00, 4'd0);
        tick;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL inc_gnt got=%b exp=0100", GNT); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL inc_busy1 got=%b exp=1", BUSY); end
        total++; if (Q !== 4'sd3) begin bad++; $display("FAIL inc_q_early got=%0d exp=3", Q); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== 4'sd4) begin bad++; $display("FAIL inc_q got=%0d exp=4", Q); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL inc_busy2 got=%b exp=1", BUSY); end
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL inc_gnt_off got=%b exp=0000", GNT); end
        tick;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL inc_busy3 got=%b exp=0", BUSY); end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        run_op(3, 2'b11, 4'd0);
        REQ = 4'b1111;
        OP = 8'h00;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            tick;
            total++; if (GNT !== eg) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, GNT, eg); end
            if (k == 4) REQ = 4'b0000;
            tick;
            total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rr_gap_a%0d got=%b exp=0000", k, GNT); end
            total++; if (Q !== 4'(k + 1)) begin bad++; $display("FAIL rr_q%0d got=%0d exp=%0d", k, Q, k + 1); end
            tick;
            total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rr_gap_b%0d got=%b exp=0000", k, GNT); end
        end
    endtask

    task automatic test_wrap;
        logic [3:0] e_inc;
        logic [3:0] e_dec;
        logic       w_dec;
`ifdef V_COUNTER_SCHED_SAT_EN
        e_inc = 4'b0111;
        e_dec = 4'b0110;
        w_dec = 1'b0;
`else
        e_inc = 4'b1000;
        e_dec = 4'b0111;
        w_dec = 1'b1;
`endif
        run_op(1, 2'b10, 4'b0111);
        total++; if (Q !== 4'sd7) begin bad++; $display("FAIL wrap_load got=%0d exp=7", Q); end
        REQ = 4'b0000;
        post(3, 2'b00, 4'd0);
        tick;
        total++; if (GNT !== 4'b1000 || WRAP !== 1'b0) begin bad++; $display("FAIL wrap_inc_gnt got=%b/%b exp=1000/0", GNT, WRAP); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== e_inc) begin bad++; $display("FAIL wrap_inc_q got=%0d exp=%0d", Q, $signed(e_inc)); end
        total++; if (WRAP !== 1'b1) begin bad++; $display("FAIL wrap_inc_pulse got=%b exp=1", WRAP); end
        tick;
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL wrap_inc_clear got=%b exp=0", WRAP); end
        post(0, 2'b01, 4'd0);
        tick;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL wrap_dec_gnt got=%b exp=0001", GNT); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== e_dec) begin bad++; $display("FAIL wrap_dec_q got=%0d exp=%0d", Q, $signed(e_dec)); end
        total++; if (WRAP !== w_dec) begin bad++; $display("FAIL wrap_dec_pulse got=%b exp=%b", WRAP, w_dec); end
        tick;
    endtask

    task automatic test_load_clear;
        REQ = 4'b0000;
        post(0, 2'b10, 4'b1101);
        tick;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL ld_gnt got=%b exp=0001", GNT); end
        REQ = 4'b0000;
        DIN[3:0] = 4'b0101;
        tick;
        total++; if (Q !== 4'b1101) begin bad++; $display("FAIL ld_q got=%0d exp=-3", Q); end
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL ld_wrap got=%b exp=0", WRAP); end
        tick;
        post(2, 2'b11, 4'd0);
        tick;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL clr_gnt got=%b exp=0100", GNT); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== 4'b0000) begin bad++; $display("FAIL clr_q got=%0d exp=0", Q); end
        total++; if (WRAP !== 1'b0) begin bad++; $display("FAIL clr_wrap got=%b exp=0", WRAP); end
        tick;
    endtask

    task automatic test_mid_reset;
        run_op(3, 2'b10, 4'd2);
        total++; if (Q !== 4'sd2) begin bad++; $display("FAIL mr_pre_q got=%0d exp=2", Q); end
        REQ = 4'b0000;
        post(2, 2'b10, 4'd5);
        tick;
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL mr_gnt got=%b exp=0100", GNT); end
        R = 1'b1;
        tick;
        total++; if (Q !== 4'b0000) begin bad++; $display("FAIL mr_q got=%0d exp=0", Q); end
        total++; if (GNT !== 4'b0000 || BUSY !== 1'b0 || WRAP !== 1'b0) begin bad++; $display("FAIL mr_outs got=%b/%b/%b exp=0000/0/0", GNT, BUSY, WRAP); end
        R = 1'b0;
        REQ = 4'b0000;
        post(0, 2'b00, 4'd0);
        post(3, 2'b00, 4'd0);
        tick;
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL mr_next_gnt got=%b exp=0001", GNT); end
        REQ = 4'b0000;
        tick;
        total++; if (Q !== 4'sd1) begin bad++; $display("FAIL mr_next_q got=%0d exp=1", Q); end
        tick;
    endtask

    initial begin
        R = 1'b1;
        REQ = 4'b0000;
        OP = 8'h00;
        DIN = 16'h0000;
        test_reset;
        test_single_inc;
        test_round_robin;
        test_wrap;
        test_load_clear;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
